div_tc_16_16_seq: RTL and testbench

Sequential 16-bit by 16-bit two's-complement divider: the inverse of the team's pipelined signed multiplier. It sits on the same datapath and takes operand pairs over a valid/ready handshake. It produces quotient and remainder by iterative restoring division on magnitudes, with sign correction at the end. Throughput is one division per 18 cycles; the area-lean iterative structure is deliberate.

---
 rtl/div_tc_16_16_seq_if.sv | 23 ++
 rtl/div_tc_16_16_seq.sv | 119 +++++++++++
 tb/tb_div_tc_16_16_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_tc_16_16_seq_if.sv
// rtl/div_tc_16_16_seq_if.sv - operand/result handshake bundle for the signed sequential divider
interface div_tc_16_16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/div_tc_16_16_seq.sv
// rtl/div_tc_16_16_seq.sv - 16/16 two's-complement divider, restoring, one bit per cycle
module div_tc_16_16_seq (
  input  logic                 clk,
  input  logic                 rstn,
  div_tc_16_16_seq_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] bmag_q, bmag_d;
  logic        sign_q_q, sign_q_d;
  logic        sign_r_q, sign_r_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        overflow_q, overflow_d;

  logic [15:0] amag_in, bmag_in;
  logic [16:0] shifted;
  logic        ge;
  logic [15:0] rem_step, qmag;

  // Magnitudes fit 16 unsigned bits: |-32768| = 16'h8000.
  assign amag_in = bus.a[15] ? (16'd0 - bus.a) : bus.a;
  assign bmag_in = bus.b[15] ? (16'd0 - bus.b) : bus.b;

  // Partial remainder stays below |b| <= 32768, so the 16-bit difference never wraps.
  assign shifted  = {rem_q, dvd_q[15]};
  assign ge       = shifted >= {1'b0, bmag_q};
  assign rem_step = ge ? (shifted[15:0] - bmag_q) : shifted[15:0];
  assign qmag     = {dvd_q[14:0], ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    bmag_d      = bmag_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_q_d   = bus.a[15] ^ bus.b[15];
          sign_r_d   = bus.a[15];
          bmag_d     = bmag_in;
          dvd_d      = amag_in;
          rem_d      = 16'd0;
          cnt_d      = 4'd0;
          div_zero_d = (bus.b == 16'd0);
          overflow_d = (bus.a == 16'h8000) && (bus.b == 16'hFFFF);
          if (bus.b == 16'd0) begin
            quotient_d  = bus.a[15] ? 16'h8000 : 16'h7FFF;
            remainder_d = bus.a;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        dvd_d = qmag;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          quotient_d  = sign_q_q ? (16'd0 - qmag) : qmag;
          remainder_d = sign_r_q ? (16'd0 - rem_step) : rem_step;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rem_q       <= 16'd0;
      dvd_q       <= 16'd0;
      bmag_q      <= 16'd0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      bmag_q      <= bmag_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_div_tc_16_16_seq.sv
// tb/tb_div_tc_16_16_seq.sv - directed bench for div_tc_16_16_seq
module tb_div_tc_16_16_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  div_tc_16_16_seq_if bus ();

  div_tc_16_16_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_quotient"},  {16'd0, bus.quotient},  32'd0);
    chk({tag, "_remainder"}, {16'd0, bus.remainder}, 32'd0);
    chk({tag, "_div_zero"},  {31'd0, bus.div_zero},  32'd0);
    chk({tag, "_overflow"},  {31'd0, bus.overflow},  32'd0);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the handshake edge.
  task automatic do_div(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input logic eov, input int elat, input int hold);
    int n;
    chk({tag, "_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"},   n, elat);
    chk({tag, "_quotient"},  {16'd0, bus.quotient},  {16'd0, eq});
    chk({tag, "_remainder"}, {16'd0, bus.remainder}, {16'd0, er});
    chk({tag, "_div_zero"},  {31'd0, bus.div_zero},  {31'd0, edz});
    chk({tag, "_overflow"},  {31'd0, bus.overflow},  {31'd0, eov});
    chk({tag, "_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.a = 16'(i * 7 + 3);
      bus.b = 16'(i + 1);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, bus.in_ready},  32'd0);
      chk({tag, "_hold_q"},     {16'd0, bus.quotient},  {16'd0, eq});
      chk({tag, "_hold_r"},     {16'd0, bus.remainder}, {16'd0, er});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {31'd0, bus.in_ready},  32'd1);
    chk({tag, "_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = 16'd0;
    bus.b = 16'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    do_div("p100_7",   16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 16, 0);
    do_div("n100_7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 16, 0);
    do_div("p100_n7",  16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 16, 0);
    do_div("n100_n7",  16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 16, 0);
    do_div("ovf",      16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 16, 0);
    do_div("dz_pos",   16'd5,    16'd0,    16'h7FFF, 16'h0005, 1'b1, 1'b0, 0,  0);
    do_div("dz_neg",   16'hFFFB, 16'd0,    16'h8000, 16'hFFFB, 1'b1, 1'b0, 0,  0);
    do_div("max_1",    16'h7FFF, 16'd1,    16'h7FFF, 16'h0000, 1'b0, 1'b0, 16, 0);
    do_div("min_2",    16'h8000, 16'd2,    16'hC000, 16'h0000, 1'b0, 1'b0, 16, 0);
    do_div("small_big", 16'hFFFD, 16'h8000, 16'h0000, 16'hFFFD, 1'b0, 1'b0, 16, 0);
    do_div("bp1000_3", 16'd1000, 16'd3,    16'd333,  16'd1,    1'b0, 1'b0, 16, 5);

    // Abort at CALC step 8, then confirm a fresh operation still works.
    bus.a = 16'd1000;
    bus.b = 16'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_calc_busy", {31'd0, bus.in_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk_idle_zero("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    do_div("after_rst_9_2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 1'b0, 16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
